// File: rtl/cim_tile_model.sv
// cim_tile_model: binary-weight compute-in-memory crossbar tile.
// An xbar_size x xbar_size array of 1-bit weights multiplies a vector of
// datatype_size-bit inputs, one crossbar row per cycle, into per-column
// accumulators; the LATCH state narrows each sum into a result register.
// Optional feature macro: CIM_SATURATE_EN -- when defined, results clamp to
// 2^datatype_size-1; otherwise the low datatype_size bits are kept (wrap).
module cim_tile_model #(
  parameter int xbar_size     = 128,
  parameter int datatype_size = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr_en,
  input  logic [$clog2(xbar_size)-1:0] i_wr_addr,
  input  logic [datatype_size-1:0]     i_wr_data,
  input  logic                         i_start,
  output logic                         o_busy,
  input  logic [$clog2(xbar_size)-1:0] i_rd_addr,
  output logic [datatype_size-1:0]     o_rd_data,
  input  logic                         i_wt_we,
  input  logic [$clog2(xbar_size)-1:0] i_wt_row,
  input  logic [$clog2(xbar_size)-1:0] i_wt_col,
  input  logic                         i_wt_data
);

  localparam int IDX_W = $clog2(xbar_size);
  localparam int ACC_W = IDX_W + datatype_size;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_LATCH   = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [IDX_W-1:0]         r_row;
  logic                     r_busy;
  logic [datatype_size-1:0] r_rd_data;

  logic [datatype_size-1:0] r_input  [xbar_size];
  logic [xbar_size-1:0]     r_weight [xbar_size];
  logic [ACC_W-1:0]         r_acc    [xbar_size];
  logic [datatype_size-1:0] r_result [xbar_size];

  logic w_idle;
  logic w_start_acc;
  logic w_last_row;

  assign w_idle      = (r_state == S_IDLE);
  assign w_start_acc = w_idle && i_start;
  assign w_last_row  = (r_row == IDX_W'(xbar_size - 1));

  // Narrow a column sum to the result width (clamp or wrap).
  function automatic logic [datatype_size-1:0] f_acc_to_result(input logic [ACC_W-1:0] acc);
`ifdef CIM_SATURATE_EN
    if (acc > ACC_W'((2 ** datatype_size) - 1)) begin
      return '1;
    end
    return datatype_size'(acc);
`else
    return datatype_size'(acc);
`endif
  endfunction

  // Next-state logic: one pass over all rows, then a single latch cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_state_nxt = S_COMPUTE;
      S_COMPUTE: if (w_last_row) w_state_nxt = S_LATCH;
      S_LATCH:   w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State register, registered busy flag and row counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      if (w_start_acc) begin
        r_row <= '0;
      end else if (r_state == S_COMPUTE) begin
        r_row <= r_row + IDX_W'(1);
      end
    end
  end

  // Input vector and weight array: writable only while idle, never reset.
  always_ff @(posedge clk) begin
    if (w_idle && i_wr_en) begin
      r_input[i_wr_addr] <= i_wr_data;
    end
    if (w_idle && i_wt_we) begin
      r_weight[i_wt_row][i_wt_col] <= i_wt_data;
    end
  end

  // Column accumulators and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < xbar_size; c++) begin
        r_acc[c]    <= '0;
        r_result[c] <= '0;
      end
    end else if (w_start_acc) begin
      for (int c = 0; c < xbar_size; c++) begin
        r_acc[c] <= '0;
      end
    end else if (r_state == S_COMPUTE) begin
      for (int c = 0; c < xbar_size; c++) begin
        if (r_weight[r_row][c]) begin
          r_acc[c] <= r_acc[c] + ACC_W'(r_input[r_row]);
        end
      end
    end else if (r_state == S_LATCH) begin
      for (int c = 0; c < xbar_size; c++) begin
        r_result[c] <= f_acc_to_result(r_acc[c]);
      end
    end
  end

  // Registered result read port, active in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_result[i_rd_addr];
    end
  end

  assign o_busy    = r_busy;
  assign o_rd_data = r_rd_data;

endmodule

// File: doc/cim_tile_model.md
CIM_TILE_MODEL -- requirements
Module: cim_tile_model

Interface
REQ-001 SHALL have parameter xbar_size, default 128, giving the crossbar rows and columns.
REQ-002 SHALL have parameter datatype_size, default 2, giving the input and result element width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_wr_en, input, 1 bit: input-vector write strobe.
REQ-006 SHALL have port i_wr_addr, input, $clog2(xbar_size) bits: input-vector row index.
REQ-007 SHALL have port i_wr_data, input, datatype_size bits: input element.
REQ-008 SHALL have port i_start, input, 1 bit: MVM start request.
REQ-009 SHALL have port o_busy, output, 1 bit: compute in progress; drives the layer's i_cim_busy.
REQ-010 SHALL have port i_rd_addr, input, $clog2(xbar_size) bits: result column index.
REQ-011 SHALL have port o_rd_data, output, datatype_size bits: registered column result.
REQ-012 SHALL have port i_wt_we, input, 1 bit: weight cell write strobe.
REQ-013 SHALL have port i_wt_row, input, $clog2(xbar_size) bits: weight cell row.
REQ-014 SHALL have port i_wt_col, input, $clog2(xbar_size) bits: weight cell column.
REQ-015 SHALL have port i_wt_data, input, 1 bit: binary weight value.

Function
REQ-016 SHALL hold an xbar_size x datatype_size input register, an xbar_size x xbar_size 1-bit weight array, per-column accumulators of $clog2(xbar_size)+datatype_size bits, and per-column result registers of datatype_size bits.
REQ-017 SHALL implement FSM IDLE -> COMPUTE -> LATCH -> IDLE; o_busy SHALL be registered and high exactly when state != IDLE.
REQ-018 In IDLE, when i_start=1 the FSM SHALL go to COMPUTE, clear all accumulators and set the row counter to 0.
REQ-019 In COMPUTE, each cycle every column c SHALL add input[row] to its accumulator if weight[row][c]=1, then increment row; after row xbar_size-1 the FSM SHALL go to LATCH.
REQ-020 In LATCH, each accumulator SHALL be converted per REQ-029/030 into its result register, then the FSM SHALL return to IDLE.
REQ-021 o_busy SHALL be high for exactly xbar_size+1 cycles, starting the cycle after i_start is sampled in IDLE.
REQ-022 i_start SHALL be ignored while o_busy=1, with no queuing.
REQ-023 i_wr_en and i_wt_we SHALL take effect only in IDLE and SHALL be ignored while busy.
REQ-024 A write accepted in the same cycle as an accepted i_start SHALL be applied and used by that compute.
REQ-025 o_rd_data SHALL equal result[i_rd_addr] one cycle after i_rd_addr is sampled, in every state.
REQ-026 During compute, reads SHALL return the previous results; new results SHALL be readable from the first cycle o_busy=0.
REQ-027 The input register and weight array SHALL retain their contents across operations.

Reset
REQ-028 On rst=0, asynchronously: state=IDLE, o_busy=0, o_rd_data=0, row counter=0, all accumulators and result registers=0; the weight array and input register are not reset. Reset mid-COMPUTE SHALL abort the operation with results 0.

Configuration
REQ-029 With CIM_SATURATE_EN defined, a result SHALL be min(acc, 2^datatype_size-1).
REQ-030 Without CIM_SATURATE_EN, a result SHALL be acc[datatype_size-1:0] (wrap).

Verification (xbar_size=128, datatype_size=2)
REQ-031 Column 0 all weights 1, all inputs 1, start -> o_busy high 129 cycles; read col 0 = 3 with CIM_SATURATE_EN, 0 without.
REQ-032 Only weight[5][7]=1, input[5]=2, others 0, start -> col 7 = 2, all other columns 0.
REQ-033 i_start pulsed at busy cycle 10 -> ignored; busy falls after 129 cycles total; results unchanged by the pulse.
REQ-034 i_wr_en to row 5 while busy -> ignored; the next compute uses the old input[5].
REQ-035 rst low at row 60, then released -> o_busy=0, all reads 0; a rerun gives the REQ-031 result.
REQ-036 i_wr_en row 0 = 1 in the same cycle as i_start, weight[0][0]=1, others 0 -> col 0 = 1.
